// File: rtl/fetch_unit.sv
// fetch_unit
//   Consumer side of the PC's prog_ctr interface. It fetches the instruction
//   at each new prog_ctr value from instruction memory over a req/ack port.
//   It buffers {pc, instr} pairs in a small FIFO for the decoder. A flush
//   throws away both buffered and in-flight fetches.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   prog_ctr   [D]        current PC from the PC block
//   flush                 taken branch: discard buffered and in-flight fetches
//   imem_req/imem_addr    read request and address, held until imem_ack
//   imem_ack/imem_rdata   one-cycle response pulse and its data
//   instr_valid/ready     decoder handshake on the FIFO head
//   instr [W], instr_pc   head instruction and the address it came from
//   busy                  high while a memory request is outstanding
//
// state | meaning
// IDLE  | no request outstanding; decides whether to start a fetch
// REQ   | request outstanding; the response will be pushed
// DRAIN | request outstanding after a flush; the response will be dropped
module fetch_unit #(
  parameter int D     = 12,
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] prog_ctr,
  input  logic         flush,
  output logic         imem_req,
  output logic [D-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_rdata,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [W-1:0] instr,
  output logic [D-1:0] instr_pc,
  output logic         busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t         state, state_nxt;
  logic           start, push, pop;
  logic [D-1:0]   last_addr;
  logic           refetch;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [D-1:0]   pc_mem  [DEPTH];
  logic [W-1:0]   ins_mem [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // In IDLE nothing is in flight, so the FIFO count alone sets the capacity
  // limit. This ensures a started fetch always has a slot for its response.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && (refetch || prog_ctr != last_addr) && count < DEPTH_C) begin
          start     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          push      = !flush;
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The ack ends the request even if a new flush arrives in the same cycle.
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop = instr_valid && instr_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_addr <= '0;
      last_addr <= '0;
      refetch   <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else begin
      if (start) begin
        imem_addr <= prog_ctr;
        refetch   <= 1'b0;
      end
      if (push) begin
        last_addr       <= imem_addr;
        pc_mem[wr_ptr]  <= imem_addr;
        ins_mem[wr_ptr] <= imem_rdata;
      end
      // After a discarded response, the current prog_ctr must be fetched
      // even if it equals last_addr (for example, a branch to self).
      if (state == DRAIN && imem_ack) refetch <= 1'b1;
      if (flush) begin
        refetch <= 1'b1;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  assign busy        = (state != IDLE);
  assign imem_req    = busy;
  assign instr_valid = (count != '0);
  assign instr       = ins_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] prog_ctr = '0;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [8:0]  imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [8:0]  instr;
  logic [11:0] instr_pc;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int mem_lat = 2;
  int mem_cnt = 0;
  int fetch_cnt = 0;
  int valid_cycles = 0;
  logic req_d = 1'b0;
  logic [11:0] exp_q [$];

  fetch_unit #(.D(12), .W(9), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [11:0] a);
    return 9'h1A3 ^ a[8:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input logic val, input string tag);
    for (int i = 0; i < 60; i++) begin
      if (imem_req === val) break;
      step(1);
    end
    chk(tag, 32'(imem_req), 32'(val));
  endtask

  // Memory model: acks mem_lat negedges after it first sees the request.
  always @(negedge clk) begin
    if (reset || !imem_req || imem_ack) begin
      imem_ack = 1'b0;
      mem_cnt  = 0;
    end else begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = model(imem_addr);
      end
    end
  end

  // Monitor: counts fetches and checks every accepted head against the scoreboard.
  always @(negedge clk) begin
    if (imem_req && !req_d) fetch_cnt++;
    req_d = imem_req;
    if (!reset && instr_valid) valid_cycles++;
    if (!reset && instr_valid && instr_ready) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chk("instr_pc", 32'(instr_pc), 32'(e));
        chk("instr", 32'(instr), 32'(model(e)));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    // Reset values
    step(1);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_instr_pc", 32'(instr_pc), 0);
    chk("rst_busy", 32'(busy), 0);

    // T1: fetch pc 0 after reset
    reset = 1'b0;
    wait_req(1'b1, "t1_req");
    chk("t1_addr", 32'(imem_addr), 0);
    step(6);
    chk("t1_valid", 32'(instr_valid), 1);
    chk("t1_instr", 32'(instr), 32'h1A3);
    chk("t1_pc", 32'(instr_pc), 0);
    exp_q.push_back(12'h000);
    instr_ready = 1'b1;
    step(4);
    chk("t1_one_fetch", 32'(fetch_cnt), 1);

    // T2: prog_ctr 1 then 2, each delivered once
    valid_cycles = 0;
    prog_ctr = 12'h001; exp_q.push_back(12'h001); step(10);
    prog_ctr = 12'h002; exp_q.push_back(12'h002); step(10);
    chk("t2_fetches", 32'(fetch_cnt), 3);
    chk("t2_valid_cycles", 32'(valid_cycles), 2);
    chk("t2_sb_empty", 32'(exp_q.size()), 0);

    // T3: back-pressure fills the FIFO; further PCs are not fetched
    f0 = fetch_cnt;
    instr_ready = 1'b0;
    prog_ctr = 12'h000; step(6);
    prog_ctr = 12'h001; step(6);
    prog_ctr = 12'h002; step(6);
    prog_ctr = 12'h003; step(6);
    chk("t3_req_low_full", 32'(imem_req), 0);
    chk("t3_fetches", 32'(fetch_cnt - f0), 2);
    chk("t3_head_pc", 32'(instr_pc), 0);
    chk("t3_head_instr", 32'(instr), 32'(model(12'h000)));
    exp_q.push_back(12'h000); exp_q.push_back(12'h001); exp_q.push_back(12'h003);
    instr_ready = 1'b1;
    step(12);
    chk("t3_sb_empty", 32'(exp_q.size()), 0);

    // T4: flush while REQ for pc 5, with an entry for pc 4 buffered
    instr_ready = 1'b0;
    prog_ctr = 12'h004; step(6);
    chk("t4_buffered", 32'(instr_valid), 1);
    mem_lat = 6;
    prog_ctr = 12'h005;
    wait_req(1'b1, "t4_req");
    chk("t4_addr", 32'(imem_addr), 32'h005);
    flush = 1'b1; prog_ctr = 12'h040;
    step(1);
    flush = 1'b0;
    chk("t4_fifo_empty", 32'(instr_valid), 0);
    chk("t4_drain_busy", 32'(busy), 1);
    f0 = fetch_cnt;
    exp_q.push_back(12'h040);
    instr_ready = 1'b1;
    wait_req(1'b0, "t4_drain_done");
    chk("t4_no_push", 32'(instr_valid), 0);
    mem_lat = 2;
    step(12);
    chk("t4_refetch", 32'(fetch_cnt - f0), 1);
    chk("t4_sb_empty", 32'(exp_q.size()), 0);

    // T5: branch to self
    f0 = fetch_cnt;
    prog_ctr = 12'h007; exp_q.push_back(12'h007); step(8);
    flush = 1'b1; step(1); flush = 1'b0;
    exp_q.push_back(12'h007); step(8);
    chk("t5_fetches", 32'(fetch_cnt - f0), 2);
    chk("t5_sb_empty", 32'(exp_q.size()), 0);

    // T6: reset during REQ
    instr_ready = 1'b0;
    prog_ctr = 12'h0AA; step(6);
    mem_lat = 6;
    prog_ctr = 12'h100;
    wait_req(1'b1, "t6_req");
    reset = 1'b1;
    #1;
    chk("t6_req_drop", 32'(imem_req), 0);
    chk("t6_busy_drop", 32'(busy), 0);
    chk("t6_valid_drop", 32'(instr_valid), 0);
    chk("t6_instr_pc", 32'(instr_pc), 0);
    step(2);
    reset = 1'b0;
    mem_lat = 2;
    exp_q.push_back(12'h100);
    instr_ready = 1'b1;
    wait_req(1'b1, "t6_refetch_req");
    chk("t6_refetch_addr", 32'(imem_addr), 32'h100);
    step(8);
    chk("t6_sb_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
